// File: rtl/sr_cmd_driver.sv
// Drives a pulse onto the S or R input of an external SR latch, then reads the
// latch Q/Qbar back to confirm the new state, reporting completion and error.
module sr_cmd_driver #(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_set,
    output logic req_ready,
    output logic S,
    output logic R,
    input  logic q_fb,
    input  logic qbar_fb,
    output logic done,
    output logic err,
    output logic cmd_state
);

    localparam int MAX_W = (PULSE_W > TIMEOUT) ? ((PULSE_W > GAP_W) ? PULSE_W : GAP_W)
                                               : ((TIMEOUT > GAP_W) ? TIMEOUT : GAP_W);
    localparam int CW = $clog2(MAX_W + 1);

    // Counters load with length-1 and leave the state when they reach zero.
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] CHECK_LOAD = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP_W > 0) ? (GAP_W - 1) : 0);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, GAP} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          cmd_reg, cmd_next;
    logic          s_reg, s_next;
    logic          r_reg, r_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;
    logic          accept;
    logic          match;

    assign req_ready = (state_reg == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    // Q == Qbar (both low from an S=R=1 hazard, or a broken latch) is never a match.
    assign match     = (q_fb == cmd_reg) && (qbar_fb == ~cmd_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            cmd_reg   <= 1'b0;
            s_reg     <= 1'b0;
            r_reg     <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cmd_reg   <= cmd_next;
            s_reg     <= s_next;
            r_reg     <= r_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cmd_next   = cmd_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = DRIVE;
                    cnt_next   = PULSE_LOAD;
                    cmd_next   = req_set;
                end
            end
            DRIVE: begin
                if (cnt_reg == '0) begin
                    state_next = CHECK;
                    cnt_next   = CHECK_LOAD;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            CHECK: begin
                if (match || (cnt_reg == '0)) begin
                    state_next = (GAP_W > 0) ? GAP : IDLE;
                    cnt_next   = GAP_LOAD;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            GAP: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Registered outputs are derived from the next state, so S and R are mutually
    // exclusive by construction and line up exactly with the DRIVE cycles.
    always_comb begin
        s_next    = (state_next == DRIVE) && cmd_next;
        r_next    = (state_next == DRIVE) && !cmd_next;
        done_next = (state_reg == CHECK) && (state_next != CHECK);
        err_next  = done_next && !match;
    end

    assign S         = s_reg;
    assign R         = r_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign cmd_state = cmd_reg;

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Directed and randomized bench for sr_cmd_driver against a NOR-latch model and a
// transaction-level timing model of each command.
module tb_sr_cmd_driver;

    localparam int P = 4;
    localparam int G = 2;
    localparam int T = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic req_set = 1'b0;
    logic stuck = 1'b0;
    logic req_ready, S, R, q_fb, qbar_fb, done, err, cmd_state;
    logic lq = 1'b0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    // Transaction model: accept cycle, value, stuck flag, expected done cycle.
    bit active = 1'b0;
    int t_acc = 0;
    int d_exp = 0;
    bit tv = 1'b0;
    bit tst = 1'b0;
    bit ecmd = 1'b0;
    bit acc_flag = 1'b0;

    always #5 clk = ~clk;

    sr_cmd_driver #(.PULSE_W(P), .GAP_W(G), .TIMEOUT(T)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_set(req_set),
        .req_ready(req_ready),
        .S(S),
        .R(R),
        .q_fb(q_fb),
        .qbar_fb(qbar_fb),
        .done(done),
        .err(err),
        .cmd_state(cmd_state)
    );

    // Behavioural NOR latch; 'stuck' pulls both feedback lines low.
    always @(S or R) begin
        if (S === 1'b1 && R === 1'b0) lq = 1'b1;
        else if (R === 1'b1 && S === 1'b0) lq = 1'b0;
    end
    assign q_fb    = stuck ? 1'b0 : lq;
    assign qbar_fb = stuck ? 1'b0 : ~lq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) chk("s_and_r_exclusive", {31'b0, S & R}, 32'd0);
    end

    task automatic eval();
        bit in_drive, e_done, e_ready;
        in_drive = active && (cyc >= t_acc + 1) && (cyc <= t_acc + P);
        e_done   = active && (cyc == d_exp);
        e_ready  = !rst && (!active || (cyc >= d_exp + G));
        chk("S", S, in_drive && tv);
        chk("R", R, in_drive && !tv);
        chk("done", done, e_done);
        chk("err", err, e_done && tst);
        chk("req_ready", req_ready, e_ready);
        chk("cmd_state", cmd_state, ecmd);
        acc_flag = 1'b0;
        if (rst) begin
            active = 1'b0;
            ecmd   = 1'b0;
        end else if (e_ready && req_valid) begin
            active   = 1'b1;
            t_acc    = cyc;
            tv       = req_set;
            tst      = stuck;
            d_exp    = stuck ? (cyc + 1 + P + T) : (cyc + 2 + P);
            ecmd     = req_set;
            acc_flag = 1'b1;
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic s, input logic st);
        @(posedge clk);
        #1;
        cyc++;
        rst       = r;
        req_valid = v;
        req_set   = s;
        if (!active || (cyc >= d_exp + G)) stuck = st;
        #1;
        eval();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int prev;
        int nacc;
        int t0;
        logic bset;

        // Reset state, then ready on the first free cycle.
        repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Set command.
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        idle(9);
        chk("set_q_fb", q_fb, 1'b1);

        // Reset command; latch must end with Q=0, Qbar=1.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(9);
        chk("reset_q_fb", q_fb, 1'b0);
        chk("reset_qbar_fb", qbar_fb, 1'b1);

        // Redundant set commands.
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        idle(9);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        idle(9);
        chk("redundant_cmd_state", cmd_state, 1'b1);

        // Stuck feedback: timeout error.
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        t0 = cyc;
        idle(23);
        chk("stuck_idle_at_t23", req_ready, 1'b1);
        chk("stuck_elapsed", cyc - t0, 23);
        idle(2);

        // Back-to-back with req_valid held high and alternating values.
        bset = 1'b0;
        prev = -1;
        nacc = 0;
        for (int i = 0; i < 40; i++) begin
            if (acc_flag) bset = ~bset;
            drive(1'b0, 1'b1, bset, 1'b0);
            if (req_ready === 1'b1 && req_valid) begin
                if (prev >= 0) chk("b2b_spacing", cyc - prev, 8);
                prev = cyc;
                nacc++;
            end
        end
        chk("b2b_count", nacc, 5);
        idle(10);

        // Reset in the middle of DRIVE.
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_abort_ready", req_ready, 1'b1);
        chk("rst_abort_S", S, 1'b0);
        idle(20);

        // Randomized traffic including occasional stuck feedback and resets.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
        end
        idle(25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
